// File: rtl/nn_layer_seq_pkg.sv
// Shared constants, activation encodings and FSM states for the NN layer.
// Fixed-point constants are s16f (16 fraction bits).
package nn_pkg;

    localparam int DW_DEF = 17;
    localparam int XF_DEF = 16;
    localparam int WF_DEF = 12;

    localparam int PLA_BP_HI   = 32'h0005_0000;
    localparam int PLA_BP_MID  = 32'h0002_6000;
    localparam int PLA_BP_LO   = 32'h0001_0000;
    localparam int PLA_OFF_HI  = 32'h0000_D800;
    localparam int PLA_OFF_MID = 32'h0000_A000;
    localparam int PLA_OFF_LO  = 32'h0000_8000;
    localparam int ONE_S16F    = 32'h0001_0000;
    localparam int MAX_S16F    = 32'h0000_FFFF;

    localparam logic ACT_SIGMOID = 1'b0;
    localparam logic ACT_RELU    = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FLUSH,
        S_ACT
    } state_e;

endpackage

// File: rtl/nn_layer_seq_if.sv
// Weight memory read port: address and strobe out, data back one cycle later.
interface nn_layer_seq_if #(
    parameter int AW = 7,
    parameter int DW = 17
);
    logic [AW-1:0] w_addr;
    logic          w_rd;
    logic [DW-1:0] w_data;

    modport master (output w_addr, output w_rd, input w_data);
    modport slave  (input w_addr, input w_rd, output w_data);
endinterface

// File: rtl/nn_layer_seq_act_pla.sv
// Combinational activation: PLA sigmoid or ReLU clamped to [0,1).
// Input z is s16f, output is s16f in [0, 0x0FFFF].
module nn_act_pla
    import nn_pkg::*;
#(
    parameter int ZW = 26,
    parameter int DW = DW_DEF
) (
    input  logic signed [ZW-1:0] z,
    input  logic                 act_sel,
    output logic [DW-1:0]        y
);

    logic          neg;
    logic [ZW-1:0] a;
    logic [ZW-1:0] f;
    logic [ZW-1:0] r;

    always_comb begin
        neg = z[ZW-1];
        a   = neg ? $unsigned(-z) : $unsigned(z);
        f   = '0;
        r   = '0;
        y   = '0;
        if (a >= ZW'(PLA_BP_HI)) begin
            f = ZW'(ONE_S16F);
        end else if (a >= ZW'(PLA_BP_MID)) begin
            f = (a >> 5) + ZW'(PLA_OFF_HI);
        end else if (a >= ZW'(PLA_BP_LO)) begin
            f = (a >> 3) + ZW'(PLA_OFF_MID);
        end else begin
            f = (a >> 2) + ZW'(PLA_OFF_LO);
        end
        // curve is symmetric about (0, 0.5)
        r = neg ? ZW'(ONE_S16F) - f : f;
        if (act_sel == ACT_RELU) begin
            r = neg ? '0 : a;
        end
        y = (r >= ZW'(ONE_S16F)) ? DW'(MAX_S16F) : DW'(r);
    end

endmodule

// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC walks N_OUT neurons,
// streaming weights and bias from an external synchronous memory.
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int N_OUT = 13,
    parameter int DW    = DW_DEF,
    parameter int XF    = XF_DEF,
    parameter int WF    = WF_DEF,
    parameter int AW    = $clog2(N_OUT*(N_IN+1)),
    parameter int ACC_W = 2*DW+$clog2(N_IN+1)+1,
    localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 act_sel,
    input  logic [N_IN*DW-1:0]   x_vec,
    nn_layer_seq_if.master       wmem,
    output logic                 y_valid,
    output logic [IW-1:0]        y_idx,
    output logic [DW-1:0]        y_data,
    output logic                 busy,
    output logic                 done
);

    localparam int KW = $clog2(N_IN+1);
    localparam int ZW = ACC_W - WF;

    state_e                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [IW-1:0]             j_q, j_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [N_IN*DW-1:0]        x_q, x_d;
    logic                      act_q, act_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      y_valid_q, y_valid_d;
    logic [IW-1:0]             y_idx_q, y_idx_d;
    logic [DW-1:0]             y_data_q, y_data_d;
    logic                      done_q, done_d;

    logic signed [DW-1:0]      x_cur;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ZW-1:0]      z;
    logic [DW-1:0]             y_act;

    // x rotates one word per tap, so the current input is always the MSB word
    assign x_cur    = x_q[N_IN*DW-1 -: DW];
    assign prod     = x_cur * $signed(wmem.w_data);
    assign bias_ext = ACC_W'($signed(wmem.w_data)) <<< XF;
    assign z        = ZW'(acc_q >>> WF);

    nn_act_pla #(
        .ZW (ZW),
        .DW (DW)
    ) u_act (
        .z       (z),
        .act_sel (act_q),
        .y       (y_act)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        j_d       = j_q;
        addr_d    = addr_q;
        x_d       = x_q;
        act_d     = act_q;
        acc_d     = acc_q;
        y_valid_d = 1'b0;
        y_idx_d   = y_idx_q;
        y_data_d  = y_data_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d = S_MAC;
                    x_d     = x_vec;
                    act_d   = act_sel;
                    j_d     = '0;
                    k_d     = '0;
                    addr_d  = '0;
                end
            end
            S_MAC: begin
                addr_d = addr_q + AW'(1);
                if (k_q == '0) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + ACC_W'(prod);
                    x_d   = (x_q << DW) | (x_q >> ((N_IN-1)*DW));
                end
                if (k_q == KW'(N_IN)) begin
                    state_d = S_FLUSH;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_FLUSH: begin
                acc_d   = acc_q + bias_ext;
                state_d = S_ACT;
            end
            S_ACT: begin
                y_valid_d = 1'b1;
                y_idx_d   = j_q;
                y_data_d  = y_act;
                if (j_q == IW'(N_OUT-1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    j_d     = '0;
                end else begin
                    state_d = S_MAC;
                    j_d     = j_q + IW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            j_q       <= '0;
            addr_q    <= '0;
            x_q       <= '0;
            act_q     <= 1'b0;
            acc_q     <= '0;
            y_valid_q <= 1'b0;
            y_idx_q   <= '0;
            y_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            addr_q    <= addr_d;
            x_q       <= x_d;
            act_q     <= act_d;
            acc_q     <= acc_d;
            y_valid_q <= y_valid_d;
            y_idx_q   <= y_idx_d;
            y_data_q  <= y_data_d;
            done_q    <= done_d;
        end
    end

    assign wmem.w_rd   = (state_q == S_MAC);
    assign wmem.w_addr = addr_q;
    assign busy        = (state_q != S_IDLE);
    assign y_valid     = y_valid_q;
    assign y_idx       = y_idx_q;
    assign y_data      = y_data_q;
    assign done        = done_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq: default 7x13 build plus a 1x1 build.
// Expected outputs are hand-computed s16f values.
module tb_nn_layer_seq;

    localparam int N_IN  = 7;
    localparam int N_OUT = 13;
    localparam int DW    = 17;
    localparam int AW    = $clog2(N_OUT*(N_IN+1));
    localparam int IW    = $clog2(N_OUT);
    localparam int PER   = N_IN + 3;
    localparam int LAST  = PER*N_OUT + 1;
    localparam int NW    = N_OUT*(N_IN+1);
    localparam int XVW   = N_IN*DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            act_sel = 1'b0;
    logic [XVW-1:0]  x_vec = '0;
    logic            y_valid;
    logic [IW-1:0]   y_idx;
    logic [DW-1:0]   y_data;
    logic            busy;
    logic            done;

    logic            s_start = 1'b0;
    logic            s_act = 1'b0;
    logic [DW-1:0]   s_x = '0;
    logic            s_y_valid;
    logic [0:0]      s_y_idx;
    logic [DW-1:0]   s_y_data;
    logic            s_busy;
    logic            s_done;

    nn_layer_seq_if #(.AW(AW), .DW(DW)) wm ();
    nn_layer_seq_if #(.AW(1), .DW(DW)) swm ();

    nn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .act_sel (act_sel),
        .x_vec   (x_vec),
        .wmem    (wm),
        .y_valid (y_valid),
        .y_idx   (y_idx),
        .y_data  (y_data),
        .busy    (busy),
        .done    (done)
    );

    nn_layer_seq #(.N_IN(1), .N_OUT(1)) sdut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (s_start),
        .act_sel (s_act),
        .x_vec   (s_x),
        .wmem    (swm),
        .y_valid (s_y_valid),
        .y_idx   (s_y_idx),
        .y_data  (s_y_data),
        .busy    (s_busy),
        .done    (s_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] smem [2];

    always @(posedge clk) if (wm.w_rd) wm.w_data <= mem[wm.w_addr];
    always @(posedge clk) if (swm.w_rd) swm.w_data <= smem[swm.w_addr];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int            ny, done_rel, busy_err, tr_err;
    logic [DW-1:0] ydat [N_OUT];
    int            yidx [N_OUT];
    int            yrel [N_OUT];
    logic [DW-1:0] exp_y [N_OUT];

    task automatic fill(input logic [DW-1:0] w0, input logic [DW-1:0] wr,
                        input logic [DW-1:0] b);
        for (int j = 0; j < N_OUT; j++) begin
            mem[j*(N_IN+1)] = w0;
            for (int k = 1; k < N_IN; k++) mem[j*(N_IN+1)+k] = wr;
            mem[j*(N_IN+1)+N_IN] = b;
        end
    endtask

    task automatic set_exp(input logic [DW-1:0] v);
        for (int j = 0; j < N_OUT; j++) exp_y[j] = v;
    endtask

    task automatic run_layer(input logic act, input logic [XVW-1:0] x,
                             input int poke_rel);
        int   c0, rel, ph, e_addr;
        logic e_rd;
        ny = 0; done_rel = -1; busy_err = 0; tr_err = 0;
        for (int j = 0; j < N_OUT; j++) begin
            ydat[j] = '1; yidx[j] = -1; yrel[j] = -1;
        end
        @(negedge clk);
        start = 1'b1; act_sel = act; x_vec = x; c0 = cyc;
        @(negedge clk);
        start = 1'b0; act_sel = ~act; x_vec = ~x;
        for (int i = 0; i < LAST + 20 && done_rel < 0; i++) begin
            rel    = cyc - c0;
            ph     = (rel - 1) % PER;
            e_rd   = (rel < LAST) && (ph <= N_IN);
            e_addr = ((rel - 1) / PER) * (N_IN + 1) + ph;
            if (wm.w_rd !== e_rd) tr_err++;
            else if (e_rd && wm.w_addr !== AW'(e_addr)) tr_err++;
            if (busy !== (rel < LAST)) busy_err++;
            if (y_valid === 1'b1) begin
                if (ny < N_OUT) begin
                    ydat[ny] = y_data;
                    yidx[ny] = int'(y_idx);
                    yrel[ny] = rel;
                end
                ny++;
            end
            if (done === 1'b1) done_rel = rel;
            start = (rel == poke_rel) || (done === 1'b1);
            if (done_rel < 0) @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_ignored", busy, 0);
    endtask

    task automatic check_run(input string tag);
        int terr;
        terr = 0;
        check({tag, ":n_valid"}, ny, N_OUT);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s:y%0d", tag, j), ydat[j], exp_y[j]);
            if (yidx[j] != j || yrel[j] != N_IN + 4 + PER*j) terr++;
        end
        check({tag, ":idx_timing_errs"}, terr, 0);
        check({tag, ":done_rel"}, done_rel, LAST);
        check({tag, ":busy_errs"}, busy_err, 0);
        check({tag, ":trace_errs"}, tr_err, 0);
    endtask

    logic [XVW-1:0] rnd;
    int             c0, rel, bad, s_yrel, s_drel, s_berr;
    logic [DW-1:0]  s_y;

    initial begin
        rnd = XVW'({$urandom(), $urandom(), $urandom(), $urandom()});
        repeat (3) @(negedge clk);
        check("rst_outs", {y_valid, busy, done, wm.w_rd, wm.w_addr,
                           y_data, y_idx}, 0);
        check("rst_outs_small", {s_y_valid, s_busy, s_done, swm.w_rd}, 0);
        rst_n = 1'b1;

        fill('0, '0, '0); set_exp(17'h08000);
        run_layer(1'b0, rnd, 25); check_run("zero_sig_poke");

        fill('0, '0, 17'h01000); set_exp(17'h0C000);
        run_layer(1'b0, rnd, 0); check_run("bias_p1");
        fill('0, '0, 17'h1F000); set_exp(17'h04000);
        run_layer(1'b0, rnd, 0); check_run("bias_m1");
        fill('0, '0, 17'h08000); set_exp(17'h0FFFF);
        run_layer(1'b0, rnd, 0); check_run("bias_p8");
        fill('0, '0, 17'h18000); set_exp(17'h00000);
        run_layer(1'b0, rnd, 0); check_run("bias_m8");
        fill('0, '0, 17'h03000); set_exp(17'h0F000);
        run_layer(1'b0, rnd, 0); check_run("bias_p3");
        fill('0, '0, 17'h1D000); set_exp(17'h01000);
        run_layer(1'b0, rnd, 0); check_run("bias_m3");
        fill('0, '0, 17'h00800); set_exp(17'h0A000);
        run_layer(1'b0, rnd, 0); check_run("bias_p0_5");

        fill(17'h02000, '0, '0); set_exp(17'h0C000);
        run_layer(1'b0, {17'h08000, rnd[XVW-DW-1:0]}, 0); check_run("x0w0_sig");
        set_exp(17'h0FFFF);
        run_layer(1'b1, {17'h08000, rnd[XVW-DW-1:0]}, 0); check_run("x0w0_relu");
        fill(17'h01000, '0, '0); set_exp(17'h08000);
        run_layer(1'b1, {17'h08000, rnd[XVW-DW-1:0]}, 0); check_run("x0w1_relu");
        fill(17'h1E000, '0, '0); set_exp(17'h00000);
        run_layer(1'b1, {17'h08000, rnd[XVW-DW-1:0]}, 0); check_run("relu_neg");

        fill('0, '0, '0);
        for (int j = 0; j < N_OUT; j++) mem[j*(N_IN+1)+N_IN-1] = 17'h01000;
        set_exp(17'h0C000);
        run_layer(1'b1, {{(N_IN-1){17'h08000}}, 17'h0C000}, 0);
        check_run("tap_order");

        fill(17'h01000, 17'h01000, '0); set_exp(17'h0D800);
        run_layer(1'b0, {N_IN{17'h04000}}, 0); check_run("sum_all_taps");

        fill('0, '0, '0);
        for (int j = 0; j < N_OUT; j++) begin
            mem[j*(N_IN+1)+N_IN] = DW'(j * 'h200);
            exp_y[j] = (j < 8) ? DW'(j * 'h2000) : 17'h0FFFF;
        end
        run_layer(1'b1, rnd, 0); check_run("per_neuron_relu");

        @(negedge clk);
        start = 1'b1; act_sel = 1'b0; x_vec = rnd; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (5*PER + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midrun_rst_outs", {y_valid, busy, done, wm.w_rd,
                                     wm.w_addr, y_data, y_idx}, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || y_valid !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midrun_rst_no_done", bad, 0);
        run_layer(1'b1, rnd, 0); check_run("after_rst");

        smem[0] = 17'h02000; smem[1] = 17'h01000;
        s_yrel = -1; s_drel = -1; s_berr = 0; s_y = '1;
        @(negedge clk);
        s_start = 1'b1; s_x = 17'h08000; c0 = cyc;
        @(negedge clk);
        s_start = 1'b0; s_x = '0;
        for (int i = 0; i < 10; i++) begin
            rel = cyc - c0;
            if (s_busy !== (rel <= 4)) s_berr++;
            if (s_y_valid === 1'b1) begin
                s_yrel = rel; s_y = s_y_data;
            end
            if (s_done === 1'b1) s_drel = rel;
            @(negedge clk);
        end
        check("small:y_rel", s_yrel, 5);
        check("small:done_rel", s_drel, 5);
        check("small:y_data", s_y, 17'h0E000);
        check("small:busy_errs", s_berr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nn_layer_seq.md
Name: nn_layer_seq

Overview:
- Time-multiplexed, parametrised fully-connected neural-network layer.
- One shared MAC evaluates N_OUT neurons of N_IN inputs each, one neuron after another. Weights and biases are read from an external synchronous memory.
- Replaces the per-neuron hardwired instances of the current 7-13-1 network. One instance per layer, chained by the controller, so any layer size is covered. Activation (PLA sigmoid or saturated ReLU) is selected per run.

Parameters:
- N_IN, 7, inputs per neuron (>=1)
- N_OUT, 13, neurons in the layer (>=1)
- DW, 17, data/weight word width
- XF, 16, fraction bits of x and y (s16f)
- WF, 12, fraction bits of weights and bias (s4i12f)
- AW, $clog2(N_OUT*(N_IN+1)), weight address width
- ACC_W, 2*DW+$clog2(N_IN+1)+1, accumulator width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; accepted only in IDLE
- act_sel  in  1  activation select, sampled with start: 0 = PLA sigmoid, 1 = ReLU clamped to [0,1)
- x_vec  in  N_IN*DW  input vector, s16f; x0 in the MSBs; sampled with start
- w_addr  out  AW  weight memory read address
- w_rd  out  1  read strobe
- w_data  in  DW  s4i12f; valid exactly 1 cycle after w_rd
- y_valid  out  1  one-cycle pulse per neuron result
- y_idx  out  $clog2(N_OUT)  neuron index of y_data
- y_data  out  DW  neuron output, s16f, always in [0, 0x0FFFF]
- busy  out  1  run in progress
- done  out  1  one-cycle pulse with the last y_valid

Behaviour:
- Reset (async assert; release takes effect on the next clk edge):
  - FSM goes to IDLE.
  - All outputs are 0. Accumulator, x latch and neuron/tap counters are cleared.
  - Reset mid-run aborts the run with no done pulse.
- Memory layout: neuron j, tap k sits at address j*(N_IN+1)+k. Taps 0..N_IN-1 are weights; tap N_IN is the bias.
- FSM states:
  - IDLE: start=1 at edge E0 latches x_vec and act_sel, sets busy, goes to MAC with j=0.
  - MAC: lasts N_IN+1 cycles. Cycle k (k=0..N_IN) drives w_rd=1 and w_addr=j*(N_IN+1)+k. The accumulator is cleared on k=0. Data of tap k-1 is accumulated at cycle k.
  - FLUSH: 1 cycle; w_rd=0; accumulates the bias tap.
  - ACT: 1 cycle; applies the activation and registers the result.
  - Next state: MAC for j+1 (j<N_OUT-1), or IDLE.
- Output timing: y_valid, y_idx=j and y_data appear the cycle after ACT. This overlaps the first MAC cycle of neuron j+1.
- Neuron period is N_IN+3 cycles. The first y_valid comes N_IN+4 cycles after E0.
- done pulses with the last y_valid. busy drops in the same cycle as done is asserted, i.e. busy is high from E0+1 through the cycle before done.
- start while busy is ignored. start coinciding with the done cycle is ignored. x_vec and act_sel are don't-care outside the start cycle.
- Arithmetic:
  - Product x*w is 2*DW signed with XF+WF fraction bits.
  - Bias is sign-extended and shifted left by XF.
  - The accumulator is full precision and never overflows.
  - z = acc >>> WF (arithmetic), giving XF fraction bits, truncated.
- PLA sigmoid on a=|z| (thresholds in real units):
  - a>=5: f=1
  - 2.375<=a<5: f=a/32+0.84375
  - 1<=a<2.375: f=a/8+0.625
  - a<1: f=a/4+0.5
  - For z<0: y=1-f. Slopes are shifts only.
  - The result is clamped to [0, 0x0FFFF]; 1.0 maps to 0x0FFFF.
- ReLU mode: z<0 gives 0; z>=1.0 gives 0x0FFFF; otherwise the XF fraction bits of z.

Decomposition:
- Package nn_pkg holds:
  - DW, XF, WF defaults
  - PLA breakpoints (5.0, 2.375, 1.0) and offsets (0.84375, 0.625, 0.5) as s16f constants
  - the act_sel encodings and the FSM state enum
- One sub-module, nn_act_pla. It is combinational: z in, act_sel in, y out. It is reused by the future single-neuron output stage.
- FSM, address generator and MAC stay in nn_layer_seq.

Test Plan:
- Defaults, all memory 0, x arbitrary, sigmoid mode -> 13 y_valid pulses, y_data=0x08000, y_idx 0..12. First pulse at E0+11, then every 10 cycles; done with the last at E0+131.
- Bias=0x01000 (1.0), weights 0, sigmoid -> y=0x0C000. Bias=0x1F000 (-1.0) -> y=0x04000. Bias=0x08000 (8.0) -> 0x0FFFF. Bias=-8.0 -> 0x00000.
- x0=0x08000 (0.5), w0=0x02000 (2.0), other taps 0 -> z=1.0, y=0x0C000. Same with act_sel=1 -> 0x0FFFF. w0=0x01000 with act_sel=1 -> 0x08000.
- Check the address trace: w_addr 0..7 for neuron 0, 8..15 for neuron 1, w_rd low in FLUSH/ACT. Assert start again mid-run -> no effect on the trace or outputs.
- Assert rst_n low during neuron 5 -> all outputs 0 immediately, no done. A new start after release -> full correct run from neuron 0.
- N_IN=1, N_OUT=1 build -> period 4, single y_valid at E0+5 with done, busy high E0+1..E0+4.
